// File: rtl/sdram_port_arbiter.sv
// Three-port request/acknowledge arbiter in front of the SDRAM controller; one transaction at a time.
// Define ARB_STARVE_GUARD_EN to add the port-2 starvation guard (default build: fixed priority 1 > 0 > 2).
//
// state  | meaning
// IDLE   | no transaction; arbitrate among pN_req and latch the winner in grant
// ISSUE  | mem_req high, granted port's fields muxed to the controller, waiting for mem_op_begun
// RDWAIT | read accepted by the controller, waiting for mem_rdata_valid
module sdram_port_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_op_begun,
  output logic              p0_rdata_valid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_op_begun,
  output logic              p1_rdata_valid,
  input  logic              p2_req,
  input  logic              p2_we,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [DATA_W-1:0] p2_wdata,
  output logic              p2_op_begun,
  output logic              p2_rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_op_begun,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              mem_req_q, mem_req_d;
  logic              ack, rvalid;
  logic              ack_out, rvalid_out, issue_live;
  logic              g_req, g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              p2_win;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;
  assign p2_win = p2_req && (starve_q == CNT_W'(STARVE_LIMIT));
`else
  assign p2_win = 1'b0;
`endif

  always_comb begin
    g_req   = 1'b0;
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    case (grant_q)
      2'd0: begin g_req = p0_req; g_we = p0_we; g_addr = p0_addr; g_wdata = p0_wdata; end
      2'd1: begin g_req = p1_req; g_we = p1_we; g_addr = p1_addr; g_wdata = p1_wdata; end
      2'd2: begin g_req = p2_req; g_we = p2_we; g_addr = p2_addr; g_wdata = p2_wdata; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack     = 1'b0;
    rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (p2_win) begin
          grant_d = 2'd2;
          state_d = ISSUE;
        end else if (p1_req) begin
          grant_d = 2'd1;
          state_d = ISSUE;
        end else if (p0_req) begin
          grant_d = 2'd0;
          state_d = ISSUE;
        end else if (p2_req) begin
          grant_d = 2'd2;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A dropped request wins over a same-cycle accept: the requester has already walked away.
        if (!g_req) begin
          state_d = IDLE;
        end else if (mem_op_begun) begin
          ack = 1'b1;
          if (g_we) begin
            state_d = IDLE;
          end else if (mem_rdata_valid) begin
            rvalid  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        if (mem_rdata_valid) begin
          rvalid  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d == ISSUE);
  end

`ifdef ARB_STARVE_GUARD_EN
  // With p2_req high in IDLE a grant always happens, and the count never passes the limit.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!p2_req || grant_d == 2'd2) starve_d = '0;
      else                            starve_d = starve_q + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 2'd0;
      mem_req_q <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mem_req_q <= mem_req_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q  <= starve_d;
`endif
    end
  end

  assign ack_out    = ack && !reset;
  assign rvalid_out = rvalid && !reset;
  assign issue_live = (state_q == ISSUE) && !reset;

  assign p0_op_begun    = ack_out && (grant_q == 2'd0);
  assign p1_op_begun    = ack_out && (grant_q == 2'd1);
  assign p2_op_begun    = ack_out && (grant_q == 2'd2);
  assign p0_rdata_valid = rvalid_out && (grant_q == 2'd0);
  assign p1_rdata_valid = rvalid_out && (grant_q == 2'd1);
  assign p2_rdata_valid = rvalid_out && (grant_q == 2'd2);

  assign mem_req   = mem_req_q;
  assign mem_we    = issue_live && g_we;
  assign mem_addr  = issue_live ? g_addr : '0;
  assign mem_wdata = issue_live ? g_wdata : '0;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter; expected grant order follows ARB_STARVE_GUARD_EN.
module tb_sdram_port_arbiter;

  logic        clk50;
  logic        reset;
  logic [2:0]  p_req, p_we;
  logic [24:0] p_addr [3];
  logic [15:0] p_wdata [3];
  logic [2:0]  op_vec, rv_vec;
  logic [15:0] rdata;
  logic        mem_req, mem_we;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_op_begun;
  logic [15:0] mem_rdata;
  logic        mem_rdata_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_rd;
    logic [1:0]  port;
    logic        we;
    logic [24:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  sdram_port_arbiter #(.ADDR_W(25), .DATA_W(16), .STARVE_LIMIT(8)) dut (
    .clk50          (clk50),
    .reset          (reset),
    .p0_req         (p_req[0]),
    .p0_we          (p_we[0]),
    .p0_addr        (p_addr[0]),
    .p0_wdata       (p_wdata[0]),
    .p0_op_begun    (op_vec[0]),
    .p0_rdata_valid (rv_vec[0]),
    .p1_req         (p_req[1]),
    .p1_we          (p_we[1]),
    .p1_addr        (p_addr[1]),
    .p1_wdata       (p_wdata[1]),
    .p1_op_begun    (op_vec[1]),
    .p1_rdata_valid (rv_vec[1]),
    .p2_req         (p_req[2]),
    .p2_we          (p_we[2]),
    .p2_addr        (p_addr[2]),
    .p2_wdata       (p_wdata[2]),
    .p2_op_begun    (op_vec[2]),
    .p2_rdata_valid (rv_vec[2]),
    .rdata          (rdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_op_begun   (mem_op_begun),
    .mem_rdata      (mem_rdata),
    .mem_rdata_valid(mem_rdata_valid)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  // Strobe monitor: every ack / read strobe must match the head of the scoreboard.
  always @(negedge clk50) begin
    exp_t e;
    if (!reset) begin
      if (op_vec != 3'b000) begin
        if (sb.size() == 0 || sb[0].is_rd) begin
          chk("unexpected_ack", {61'd0, op_vec}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_port", {61'd0, op_vec}, {61'd0, 3'b001 << e.port});
          chk("ack_with_mem_op", {63'd0, mem_op_begun}, 64'd1);
          chk("ack_we", {63'd0, mem_we}, {63'd0, e.we});
          chk("ack_addr", {39'd0, mem_addr}, {39'd0, e.addr});
          if (e.we) chk("ack_wdata", {48'd0, mem_wdata}, {48'd0, e.data});
        end
      end
      if (rv_vec != 3'b000) begin
        if (sb.size() == 0 || !sb[0].is_rd) begin
          chk("unexpected_rvalid", {61'd0, rv_vec}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rvalid_port", {61'd0, rv_vec}, {61'd0, 3'b001 << e.port});
          chk("rdata", {48'd0, rdata}, {48'd0, e.data});
        end
      end
    end
  end

  task automatic do_write(input int port, input logic [24:0] addr, input logic [15:0] data,
                          input int wait_cycles);
    tick();
    p_req[port] = 1'b1; p_we[port] = 1'b1; p_addr[port] = addr; p_wdata[port] = data;
    sb.push_back('{1'b0, 2'(port), 1'b1, addr, data});
    repeat (wait_cycles) begin
      tick();
      @(negedge clk50);
      chk("wr_wait_req", {63'd0, mem_req}, 64'd1);
      chk("wr_wait_noack", {61'd0, op_vec}, 64'd0);
    end
    tick();
    mem_op_begun = 1'b1;
    @(negedge clk50);
    chk("wr_ack_req", {63'd0, mem_req}, 64'd1);
    tick();
    mem_op_begun = 1'b0;
    p_req[port] = 1'b0;
    @(negedge clk50);
    chk("wr_back_idle", {63'd0, mem_req}, 64'd0);
  endtask

  // gap = 0: data arrives with the accept; otherwise gap cycles after the accept.
  task automatic do_read(input int port, input logic [24:0] addr, input logic [15:0] data,
                         input int gap);
    tick();
    p_req[port] = 1'b1; p_we[port] = 1'b0; p_addr[port] = addr;
    sb.push_back('{1'b0, 2'(port), 1'b0, addr, 16'h0});
    sb.push_back('{1'b1, 2'(port), 1'b0, addr, data});
    tick();
    mem_op_begun = 1'b1;
    if (gap == 0) begin
      mem_rdata_valid = 1'b1;
      mem_rdata = data;
    end
    @(negedge clk50);
    tick();
    mem_op_begun = 1'b0; p_req[port] = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = 16'h0;
    if (gap == 0) begin
      @(negedge clk50);
      chk("rd_same_idle", {63'd0, mem_req}, 64'd0);
      tick();
      mem_rdata_valid = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clk50);
      chk("rd_stray_after_idle", {61'd0, rv_vec}, 64'd0);
      tick();
      mem_rdata_valid = 1'b0; mem_rdata = 16'h0;
    end else begin
      repeat (gap - 1) begin
        @(negedge clk50);
        chk("rd_wait_nodata", {61'd0, rv_vec}, 64'd0);
        chk("rd_wait_noreq", {63'd0, mem_req}, 64'd0);
        tick();
      end
      mem_rdata_valid = 1'b1; mem_rdata = data;
      @(negedge clk50);
      tick();
      mem_rdata_valid = 1'b0; mem_rdata = 16'h0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int acked;
    int exp_port;
    reset = 1'b1;
    p_req = 3'b111;
    p_we  = 3'b111;
    p_addr[0] = 25'h00000A0; p_addr[1] = 25'h00000B1; p_addr[2] = 25'h00000C2;
    p_wdata[0] = 16'h1110;   p_wdata[1] = 16'h2221;   p_wdata[2] = 16'h3332;
    mem_op_begun = 1'b0; mem_rdata = 16'h0; mem_rdata_valid = 1'b0;

    // reset held with every port requesting
    repeat (3) begin
      @(posedge clk50);
      @(negedge clk50);
      chk("rst_ctl", {57'd0, mem_req, mem_we, op_vec, rv_vec}, 64'd0);
      chk("rst_bus", {7'd0, mem_addr, mem_wdata, rdata}, 64'd0);
    end
    tick();
    reset = 1'b0;
    @(negedge clk50);
    chk("rel_no_req_yet", {63'd0, mem_req}, 64'd0);
    tick();
    @(negedge clk50);
    chk("rel_first_req", {63'd0, mem_req}, 64'd1);
    chk("rel_first_grant_p1", {39'd0, mem_addr}, {39'd0, 25'h00000B1});
    sb.push_back('{1'b0, 2'd1, 1'b1, 25'h00000B1, 16'h2221});
    tick();
    mem_op_begun = 1'b1;
    @(negedge clk50);
    tick();
    mem_op_begun = 1'b0;
    p_req = 3'b000;
    @(negedge clk50);
    chk("rel_back_idle", {63'd0, mem_req}, 64'd0);
    tick();

    do_write(0, 25'h0000010, 16'hBEEF, 2);
    do_read(2, 25'h1FFFFFF, 16'h1234, 2);
    do_read(1, 25'h0000321, 16'hA5A5, 0);

    // p2 abandons its request while in ISSUE; a late accept must be ignored
    tick();
    p_req[2] = 1'b1; p_we[2] = 1'b0; p_addr[2] = 25'h0000155;
    tick();
    @(negedge clk50);
    chk("abort_issue_req", {63'd0, mem_req}, 64'd1);
    chk("abort_issue_addr", {39'd0, mem_addr}, {39'd0, 25'h0000155});
    tick();
    p_req[2] = 1'b0;
    @(negedge clk50);
    chk("abort_no_ack", {61'd0, op_vec}, 64'd0);
    tick();
    mem_op_begun = 1'b1;
    @(negedge clk50);
    chk("abort_idle_req", {63'd0, mem_req}, 64'd0);
    chk("abort_idle_addr", {39'd0, mem_addr}, 64'd0);
    chk("abort_late_ack", {61'd0, op_vec}, 64'd0);
    tick();
    mem_op_begun = 1'b0;

    // reset while waiting for read data; the late data strobe must go nowhere
    tick();
    p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 25'h0000777;
    sb.push_back('{1'b0, 2'd0, 1'b0, 25'h0000777, 16'h0});
    tick();
    mem_op_begun = 1'b1;
    @(negedge clk50);
    tick();
    mem_op_begun = 1'b0; p_req[0] = 1'b0;
    @(negedge clk50);
    chk("rdwait_noreq", {63'd0, mem_req}, 64'd0);
    tick();
    reset = 1'b1;
    @(negedge clk50);
    chk("rst_mid_ctl", {57'd0, mem_req, mem_we, op_vec, rv_vec}, 64'd0);
    tick();
    reset = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk50);
    chk("rst_mid_no_rvalid", {61'd0, rv_vec}, 64'd0);
    tick();
    mem_rdata_valid = 1'b0; mem_rdata = 16'h0;
    tick();

    // continuous contention, each write accepted on its first ISSUE cycle
    p_we = 3'b111;
    p_addr[0] = 25'h0000A00; p_addr[1] = 25'h0000B11; p_addr[2] = 25'h0000C22;
    p_wdata[0] = 16'h0A0A;   p_wdata[1] = 16'h0B0B;   p_wdata[2] = 16'h0C0C;
    for (int g = 0; g < 18; g++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_port = (g % 9 == 8) ? 2 : (((g % 9) % 2 == 0) ? 1 : 0);
`else
      exp_port = (g % 2 == 0) ? 1 : 0;
`endif
      sb.push_back('{1'b0, 2'(exp_port), 1'b1, p_addr[exp_port], p_wdata[exp_port]});
    end
    tick();
    p_req = 3'b111;
    for (int g = 0; g < 18; g++) begin
      tick();
      p_req = 3'b111;
      mem_op_begun = 1'b1;
      @(negedge clk50);
      acked = -1;
      if (op_vec[0]) acked = 0;
      if (op_vec[1]) acked = 1;
      if (op_vec[2]) acked = 2;
      tick();
      mem_op_begun = 1'b0;
      if (acked >= 0) p_req[acked] = 1'b0;
    end
    tick();
    p_req = 3'b000;
    repeat (3) tick();
    @(negedge clk50);
    chk("final_idle", {63'd0, mem_req}, 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
